// File: rtl/knn_topk_sorter_if.sv
// Data-point stream into the KNN top-K sorter.
// Handshake: a point transfers on a rising clk edge where in_valid && in_ready;
// the master holds in_x/in_y/in_label/in_last stable while in_valid is high and in_ready is low.
interface knn_topk_sorter_if #(
  parameter int DATA_W = 16,
  parameter int LBL_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic signed [DATA_W-1:0] in_y;
  logic [LBL_W-1:0]         in_label;
  logic                     in_last;

  modport master (output in_valid, in_x, in_y, in_label, in_last, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_label, in_last, output in_ready);
endinterface

// File: rtl/knn_topk_sorter.sv
// Streaming K-nearest-neighbour selector: registered squared-distance stage followed by
// insertion into a K-deep ascending sorted register list, read out by slot select.
module knn_topk_sorter #(
  parameter  int DATA_W = 16,
  parameter  int K      = 4,
  parameter  int IDX_W  = 8,
  parameter  int LBL_W  = 8,
  localparam int DIST_W = 2 * DATA_W + 1,
  localparam int SEL_W  = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W  = $clog2(K + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] test_x,
  input  logic signed [DATA_W-1:0] test_y,
  knn_topk_sorter_if.slave         in_if,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [DIST_W-1:0]        out_dist,
  output logic [IDX_W-1:0]         out_idx,
  output logic [LBL_W-1:0]         out_label
);

  logic                     accept;
  logic signed [DATA_W:0]   dx, dy;
  logic [DIST_W-1:0]        dx_sq, dy_sq, dist_new;
  logic [IDX_W-1:0]         idx_cnt;

  logic                     s1_valid;
  logic [DIST_W-1:0]        s1_dist;
  logic [IDX_W-1:0]         s1_idx;
  logic [LBL_W-1:0]         s1_label;
  logic                     s1_last;

  logic [DIST_W-1:0]        slot_dist  [K];
  logic [IDX_W-1:0]         slot_idx   [K];
  logic [LBL_W-1:0]         slot_label [K];
  logic [DIST_W-1:0]        nxt_dist   [K];
  logic [IDX_W-1:0]         nxt_idx    [K];
  logic [LBL_W-1:0]         nxt_label  [K];
  logic [CNT_W-1:0]         count_r;
  logic                     done_r;
  int                       ins_pos;
  logic                     ins_ok;

  assign in_if.in_ready = !done_r && !clear;
  assign accept         = in_if.in_valid && in_if.in_ready;

  // Sign-extended differences; each square is < 2^(2*DATA_W), so the sum fits DIST_W bits.
  assign dx       = $signed({in_if.in_x[DATA_W-1], in_if.in_x}) - $signed({test_x[DATA_W-1], test_x});
  assign dy       = $signed({in_if.in_y[DATA_W-1], in_if.in_y}) - $signed({test_y[DATA_W-1], test_y});
  assign dx_sq    = DIST_W'(dx * dx);
  assign dy_sq    = DIST_W'(dy * dy);
  assign dist_new = dx_sq + dy_sq;

  // Position = occupied slots with dist <= new; "<=" keeps earlier indices ahead on ties.
  always_comb begin
    ins_pos = 0;
    for (int i = 0; i < K; i++) begin
      if (i < int'(count_r) && slot_dist[i] <= s1_dist) ins_pos++;
    end
  end

  assign ins_ok = (ins_pos < K);

  always_comb begin
    nxt_dist  = slot_dist;
    nxt_idx   = slot_idx;
    nxt_label = slot_label;
    for (int i = 1; i < K; i++) begin
      if (i > ins_pos) begin
        nxt_dist[i]  = slot_dist[i-1];
        nxt_idx[i]   = slot_idx[i-1];
        nxt_label[i] = slot_label[i-1];
      end
    end
    for (int i = 0; i < K; i++) begin
      if (i == ins_pos) begin
        nxt_dist[i]  = s1_dist;
        nxt_idx[i]   = s1_idx;
        nxt_label[i] = s1_label;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid <= 1'b0;
      s1_dist  <= '0;
      s1_idx   <= '0;
      s1_label <= '0;
      s1_last  <= 1'b0;
      idx_cnt  <= '0;
      count_r  <= '0;
      done_r   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        slot_dist[i]  <= '0;
        slot_idx[i]   <= '0;
        slot_label[i] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_dist  <= dist_new;
        s1_idx   <= idx_cnt;
        s1_label <= in_if.in_label;
        s1_last  <= in_if.in_last;
        idx_cnt  <= idx_cnt + IDX_W'(1);
      end
      if (s1_valid) begin
        if (ins_ok) begin
          slot_dist  <= nxt_dist;
          slot_idx   <= nxt_idx;
          slot_label <= nxt_label;
          if (count_r != CNT_W'(K)) count_r <= count_r + CNT_W'(1);
        end
        if (s1_last) done_r <= 1'b1;
      end
    end
  end

  assign done  = done_r;
  assign count = count_r;

  always_comb begin
    out_valid = 1'b0;
    out_dist  = '0;
    out_idx   = '0;
    out_label = '0;
    if (int'(sel) < K && int'(sel) < int'(count_r)) begin
      out_valid = 1'b1;
      out_dist  = slot_dist[sel];
      out_idx   = slot_idx[sel];
      out_label = slot_label[sel];
    end
  end

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Directed bench for knn_topk_sorter: table-driven streams and readouts plus
// hand-written clear / hold-after-done / reset-mid-pipeline sequences.
module tb_knn_topk_sorter;
  localparam int DATA_W = 16;
  localparam int K      = 4;
  localparam int IDX_W  = 8;
  localparam int LBL_W  = 8;
  localparam int DIST_W = 2 * DATA_W + 1;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 3;
  localparam int REC_W  = 1 + DIST_W + IDX_W + LBL_W;

  typedef struct {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic [LBL_W-1:0]         lbl;
    logic                     last;
  } pt_t;

  typedef struct {
    logic [SEL_W-1:0]  s;
    logic              v;
    logic [DIST_W-1:0] d;
    logic [IDX_W-1:0]  ix;
    logic [LBL_W-1:0]  lb;
  } rd_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clear;
  logic signed [DATA_W-1:0] test_x, test_y;
  logic                     done;
  logic [CNT_W-1:0]         count;
  logic [SEL_W-1:0]         sel;
  logic                     out_valid;
  logic [DIST_W-1:0]        out_dist;
  logic [IDX_W-1:0]         out_idx;
  logic [LBL_W-1:0]         out_label;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  pt_t pts [7];
  rd_t rds [8];

  knn_topk_sorter_if #(.DATA_W(DATA_W), .LBL_W(LBL_W)) in_if ();

  knn_topk_sorter #(.DATA_W(DATA_W), .K(K), .IDX_W(IDX_W), .LBL_W(LBL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .test_x    (test_x),
    .test_y    (test_y),
    .in_if     (in_if),
    .done      (done),
    .count     (count),
    .sel       (sel),
    .out_valid (out_valid),
    .out_dist  (out_dist),
    .out_idx   (out_idx),
    .out_label (out_label)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // checks and scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  task automatic check_slot(input string name, input logic [SEL_W-1:0] s, input logic v,
                            input logic [DIST_W-1:0] d, input logic [IDX_W-1:0] ix,
                            input logic [LBL_W-1:0] lb);
    logic [REC_W-1:0] got, want;
    exp_q.push_back({v, d, ix, lb});
    sel = s;
    #1;
    got  = {out_valid, out_dist, out_idx, out_label};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s sel=%0d actual v=%0d d=%0d idx=%0d lbl=%0d required v=%0d d=%0d idx=%0d lbl=%0d",
               name, s, got[REC_W-1], got[REC_W-2 -: DIST_W], got[IDX_W+LBL_W-1 -: IDX_W], got[LBL_W-1:0],
               want[REC_W-1], want[REC_W-2 -: DIST_W], want[IDX_W+LBL_W-1 -: IDX_W], want[LBL_W-1:0]);
    end
  endtask

  // drivers
  task automatic drive_point(input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] y,
                             input logic [LBL_W-1:0] lb, input logic last);
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_x     = x;
    in_if.in_y     = y;
    in_if.in_label = lb;
    in_if.in_last  = last;
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic run_stream(input int first, input int n);
    for (int i = first; i < first + n; i++) drive_point(pts[i].x, pts[i].y, pts[i].lbl, pts[i].last);
    go_idle();
  endtask

  initial begin
    pts[0] = '{16'sd3,  16'sd4,  8'd1, 1'b0};
    pts[1] = '{16'sd1,  16'sd1,  8'd2, 1'b0};
    pts[2] = '{16'sd5,  16'sd0,  8'd3, 1'b0};
    pts[3] = '{16'sd0,  16'sd2,  8'd4, 1'b0};
    pts[4] = '{16'sd10, 16'sd10, 8'd5, 1'b1};
    pts[5] = '{16'sd1,  16'sd0,  8'd6, 1'b0};
    pts[6] = '{16'sd0,  16'sd3,  8'd7, 1'b1};

    rds[0] = '{2'd0, 1'b1, 33'd2,  8'd1, 8'd2};
    rds[1] = '{2'd1, 1'b1, 33'd4,  8'd3, 8'd4};
    rds[2] = '{2'd2, 1'b1, 33'd25, 8'd0, 8'd1};
    rds[3] = '{2'd3, 1'b1, 33'd25, 8'd2, 8'd3};
    rds[4] = '{2'd0, 1'b1, 33'd1,  8'd0, 8'd6};
    rds[5] = '{2'd1, 1'b1, 33'd9,  8'd1, 8'd7};
    rds[6] = '{2'd2, 1'b0, 33'd0,  8'd0, 8'd0};
    rds[7] = '{2'd3, 1'b0, 33'd0,  8'd0, 8'd0};

    rst = 1'b1;
    clear = 1'b0;
    sel = '0;
    test_x = '0;
    test_y = '0;
    in_if.in_valid = 1'b0;
    in_if.in_x = '0;
    in_if.in_y = '0;
    in_if.in_label = '0;
    in_if.in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_in_ready", 64'(in_if.in_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check_slot("rst_slot0", 2'd0, 1'b0, '0, '0, '0);

    // five points into four slots: tie ordering, drop at p >= K
    run_stream(0, 5);
    wait_done("t1_done");
    check("t1_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) check_slot("t1_slot", rds[i].s, rds[i].v, rds[i].d, rds[i].ix, rds[i].lb);

    // short stream: unoccupied slots read as zero
    do_clear();
    check("t2_done_after_clear", 64'(done), 64'd0);
    run_stream(5, 2);
    wait_done("t2_done");
    check("t2_count", 64'(count), 64'd2);
    for (int i = 4; i < 8; i++) check_slot("t2_slot", rds[i].s, rds[i].v, rds[i].d, rds[i].ix, rds[i].lb);

    // extreme coordinates
    test_x = -16'sd32768;
    test_y = -16'sd32768;
    do_clear();
    drive_point(16'sd32767, 16'sd32767, 8'd7, 1'b1);
    go_idle();
    wait_done("t3_done");
    check("t3_count", 64'(count), 64'd1);
    check_slot("t3_max_dist", 2'd0, 1'b1, 33'd8589672450, 8'd0, 8'd7);

    // clear mid-stream together with a 4th offered point
    test_x = '0;
    test_y = '0;
    do_clear();
    drive_point(16'sd1, 16'sd0, 8'd1, 1'b0);
    drive_point(16'sd2, 16'sd0, 8'd2, 1'b0);
    drive_point(16'sd3, 16'sd0, 8'd3, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    in_if.in_x = 16'sd4;
    in_if.in_label = 8'd4;
    #1;
    check("t4_ready_in_clear", 64'(in_if.in_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    in_if.in_valid = 1'b0;
    check("t4_count", 64'(count), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    @(negedge clk);
    check("t4_count_later", 64'(count), 64'd0);
    check_slot("t4_slot0_empty", 2'd0, 1'b0, '0, '0, '0);
    drive_point(16'sd0, 16'sd5, 8'd9, 1'b1);
    go_idle();
    wait_done("t4_done_new");
    check("t4_count_new", 64'(count), 64'd1);
    check_slot("t4_idx_restart", 2'd0, 1'b1, 33'd25, 8'd0, 8'd9);

    // hold in_valid after done
    for (int c = 0; c < 5; c++) begin
      drive_point(16'sd0, 16'sd0, 8'd0, 1'b0);
      #1;
      check("t5_in_ready", 64'(in_if.in_ready), 64'd0);
    end
    go_idle();
    check("t5_done", 64'(done), 64'd1);
    check("t5_count", 64'(count), 64'd1);
    check_slot("t5_slot0", 2'd0, 1'b1, 33'd25, 8'd0, 8'd9);
    check_slot("t5_slot1", 2'd1, 1'b0, '0, '0, '0);

    // reset while the insertion is pending
    do_clear();
    drive_point(16'sd1, 16'sd1, 8'd3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_in_ready", 64'(in_if.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    check("t6_count_later", 64'(count), 64'd0);
    check("t6_done_later", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
